// File: rtl/alu_cmd_ctrl_if.sv
// Bundles the receive-path, ALU and transmit-path signals of the command controller.
// The master modport is the controller's view; the slave modport is its surroundings.
interface alu_cmd_ctrl_if #(
    parameter int DATAWIDTH = 8,
    parameter int FUNC      = 4
);
    logic [DATAWIDTH-1:0]   RX_P_DATA;
    logic                   RX_D_VLD;
    logic [DATAWIDTH-1:0]   ALU_A;
    logic [DATAWIDTH-1:0]   ALU_B;
    logic [FUNC-1:0]        ALU_FUNC;
    logic                   ALU_EN;
    logic [2*DATAWIDTH-1:0] ALU_OUT;
    logic                   ALU_OUT_VALID;
    logic [DATAWIDTH-1:0]   TX_P_DATA;
    logic                   TX_D_VLD;
    logic                   TX_BUSY;
    logic                   CMD_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
        output ALU_A, ALU_B, ALU_FUNC, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
        input  ALU_A, ALU_B, ALU_FUNC, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Parses RX command frames, fires the ALU for one cycle, waits for its result
// and streams the 2-byte result low byte first to the transmitter.
module alu_cmd_ctrl #(
    parameter int                   DATAWIDTH = 8,
    parameter int                   FUNC      = 4,
    parameter int                   TIMEOUT   = 16,
    parameter logic [DATAWIDTH-1:0] OP_AB     = 8'hCC,
    parameter logic [DATAWIDTH-1:0] OP_FN     = 8'hDD
) (
    input  logic          CLK,
    input  logic          RST,
    alu_cmd_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FN, EXEC, WAIT_RES, TX_LO, TX_HI
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   a_q, b_q, tx_data_q;
    logic [FUNC-1:0]        func_q;
    logic [2*DATAWIDTH-1:0] result_q;
    logic [CW-1:0]          cnt_q;
    logic                   alu_en_q, tx_vld_q, cmd_err_q;

    logic load_a, load_b, load_fn, capture, tx_next, tx_done, err, cnt_clr, cnt_inc;

    // NOTE: the reset is synchronous, so RST only takes effect on a CLK edge.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_fn = 1'b0;
        capture = 1'b0;
        tx_next = 1'b0;
        tx_done = 1'b0;
        err     = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: if (bus.RX_D_VLD) begin
                if (bus.RX_P_DATA == OP_AB)      state_d = GET_A;
                else if (bus.RX_P_DATA == OP_FN) state_d = GET_FN;
                else                             err     = 1'b1;
            end
            GET_A: if (bus.RX_D_VLD) begin
                load_a  = 1'b1;
                state_d = GET_B;
            end
            GET_B: if (bus.RX_D_VLD) begin
                load_b  = 1'b1;
                state_d = GET_FN;
            end
            GET_FN: if (bus.RX_D_VLD) begin
                load_fn = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                cnt_clr = 1'b1;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (bus.ALU_OUT_VALID) begin
                    capture = 1'b1;
                    state_d = TX_LO;
                end else if (cnt_q == CNT_LAST) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            TX_LO: if (!bus.TX_BUSY) begin
                tx_next = 1'b1;
                state_d = TX_HI;
            end
            TX_HI: if (!bus.TX_BUSY) begin
                tx_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            alu_en_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            // ALU_EN is high exactly for the EXEC cycle that follows the FUNC byte.
            alu_en_q  <= load_fn;
            cmd_err_q <= err;
            if (load_a)  a_q    <= bus.RX_P_DATA;
            if (load_b)  b_q    <= bus.RX_P_DATA;
            if (load_fn) func_q <= bus.RX_P_DATA[FUNC-1:0];

            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;

            if (capture) begin
                result_q  <= bus.ALU_OUT;
                tx_data_q <= bus.ALU_OUT[DATAWIDTH-1:0];
                tx_vld_q  <= 1'b1;
            end else if (tx_next) begin
                tx_data_q <= result_q[2*DATAWIDTH-1:DATAWIDTH];
            end else if (tx_done) begin
                tx_vld_q  <= 1'b0;
            end
        end
    end

    assign bus.ALU_A     = a_q;
    assign bus.ALU_B     = b_q;
    assign bus.ALU_FUNC  = func_q;
    assign bus.ALU_EN    = alu_en_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.CMD_ERR   = cmd_err_q;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: a small ALU model answers ALU_EN and a
// scoreboard queue holds the TX bytes each frame must produce.
module tb_alu_cmd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_cmd_ctrl_if #(.DATAWIDTH(8), .FUNC(4)) bus ();

    alu_cmd_ctrl #(.DATAWIDTH(8), .FUNC(4), .TIMEOUT(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         en_cycles  = 0;
    int         err_cycles = 0;
    int         vld_cycles = 0;
    logic       alu_en_seen   = 1'b0;
    logic       model_respond = 1'b1;
    logic [15:0] model_val    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (bus.ALU_EN)   en_cycles++;
        if (bus.CMD_ERR)  err_cycles++;
        if (bus.TX_D_VLD) vld_cycles++;
        alu_en_seen = bus.ALU_EN;
        if (!rst && bus.TX_D_VLD && !bus.TX_BUSY) begin
            check("tx_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_byte", bus.TX_P_DATA, exp_q.pop_front());
        end
    end

    // ALU model: result valid for one cycle, one cycle after ALU_EN.
    always @(posedge clk) begin
        #1;
        bus.ALU_OUT_VALID = 1'b0;
        if (alu_en_seen && model_respond) begin
            bus.ALU_OUT_VALID = 1'b1;
            bus.ALU_OUT       = model_val;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge clk); #1;
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic expect_result(input logic [15:0] res);
        model_val = res;
        exp_q.push_back(res[7:0]);
        exp_q.push_back(res[15:8]);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || bus.TX_D_VLD) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_drained"}, 32'(k < 200), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus.ALU_A, bus.ALU_B, bus.ALU_FUNC, bus.ALU_EN,
                    bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR}, 0);
    endtask

    task automatic frame_ab(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] fn, input logic [15:0] res);
        expect_result(res);
        en_cycles = 0;
        send_byte(8'hCC);
        send_byte(a);
        send_byte(b);
        send_byte(fn);
        check({tag, "_en_rise"}, bus.ALU_EN, 1);
        check({tag, "_abf"}, {bus.ALU_A, bus.ALU_B, bus.ALU_FUNC}, {a, b, fn[3:0]});
        drain(tag);
        check({tag, "_en_once"}, en_cycles, 1);
    endtask

    initial begin
        int k;
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_BUSY   = 1'b0;
        bus.ALU_OUT   = '0;
        bus.ALU_OUT_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic add-like frame
        frame_ab("t1", 8'h05, 8'h03, 8'h00, 16'h0008);

        // 2: all-ones operands, then OP_FN reusing stored A/B
        frame_ab("t2", 8'hFF, 8'hFF, 8'h02, 16'hFE01);
        expect_result(16'h0000);
        en_cycles = 0;
        send_byte(8'hDD);
        send_byte(8'hF1);
        check("t2_fn_en_rise", bus.ALU_EN, 1);
        check("t2_fn_abf", {bus.ALU_A, bus.ALU_B, bus.ALU_FUNC}, {8'hFF, 8'hFF, 4'h1});
        drain("t2_fn");
        check("t2_fn_en_once", en_cycles, 1);

        // 3: transmitter busy for 10 cycles; an RX byte meanwhile is dropped
        bus.TX_BUSY = 1'b1;
        err_cycles  = 0;
        expect_result(16'h3412);
        send_byte(8'hCC);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        k = 0;
        while (!bus.TX_D_VLD && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t3_vld_rise", bus.TX_D_VLD, 1);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold", {bus.TX_D_VLD, bus.TX_P_DATA}, {1'b1, 8'h12});
            bus.RX_P_DATA = 8'h55;
            bus.RX_D_VLD  = (i == 3);
            @(posedge clk); #1;
        end
        bus.RX_D_VLD = 1'b0;
        bus.TX_BUSY  = 1'b0;
        drain("t3");
        check("t3_no_err", err_cycles, 0);

        // 4: illegal opcode, then a normal frame
        err_cycles = 0;
        en_cycles  = 0;
        send_byte(8'h55);
        check("t4_err_pulse", bus.CMD_ERR, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("t4_err_cycles", err_cycles, 1);
        check("t4_no_en", en_cycles, 0);
        frame_ab("t4", 8'h01, 8'h02, 8'h00, 16'h0003);

        // 5: ALU never answers -> timeout error after 16 WAIT_RES cycles
        model_respond = 1'b0;
        err_cycles = 0;
        vld_cycles = 0;
        send_byte(8'hCC);
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte(8'h00);
        @(posedge clk); #1;
        k = 0;
        while (!bus.CMD_ERR && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_timeout_cycles", k, 16);
        repeat (2) begin @(posedge clk); #1; end
        check("t5_err_cycles", err_cycles, 1);
        check("t5_no_tx", vld_cycles, 0);
        model_respond = 1'b1;
        frame_ab("t5_next", 8'h04, 8'h05, 8'h01, 16'h0009);

        // 6: reset in GET_B, reset in TX_HI, then OP_FN uses zeroed A/B
        send_byte(8'hCC);
        send_byte(8'h07);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("t6_rst_get_b");
        rst = 1'b0;
        expect_result(16'hABCD);
        send_byte(8'hCC);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h00);
        k = 0;
        while (exp_q.size() != 1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_in_tx_hi", {bus.TX_D_VLD, bus.TX_P_DATA}, {1'b1, 8'hAB});
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_all_zero("t6_rst_tx_hi");
        rst = 1'b0;
        @(posedge clk); #1;
        expect_result(16'h0055);
        send_byte(8'hDD);
        send_byte(8'h00);
        check("t6_fn_en_rise", bus.ALU_EN, 1);
        check("t6_fn_ab_zero", {bus.ALU_A, bus.ALU_B}, 0);
        drain("t6_fn");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Initiator/consumer side of the ALU interface; ALU itself is Enable-driven and returns ALU_OUT with OUT_VALID.
- Parses byte-wide command frames from the receive path and loads operands and function code.
- Fires a one-cycle ALU enable, waits for the result, then streams it low byte first to the transmit path with a valid/busy handshake.
- Sits between the RX parallel-data output, the ALU and the TX parallel-data input.

Parameters:
- DATAWIDTH, 8, operand/byte width
- FUNC, 4, ALU function code width
- TIMEOUT, 16, max cycles in WAIT_RES before abort (>=2)
- OP_AB, 8'hCC, opcode: operands A, B, then FUNC follow
- OP_FN, 8'hDD, opcode: FUNC only; reuse stored A/B

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- RX_P_DATA  input  DATAWIDTH  received byte
- RX_D_VLD  input  1  one-cycle strobe, RX_P_DATA valid
- ALU_A  output  DATAWIDTH  operand A (registered)
- ALU_B  output  DATAWIDTH  operand B (registered)
- ALU_FUNC  output  FUNC  function code (registered)
- ALU_EN  output  1  one-cycle ALU enable
- ALU_OUT  input  2*DATAWIDTH  ALU result
- ALU_OUT_VALID  input  1  result strobe from ALU
- TX_P_DATA  output  DATAWIDTH  byte to transmitter
- TX_D_VLD  output  1  byte valid; held until accepted
- TX_BUSY  input  1  transmitter busy (ready = ~TX_BUSY)
- CMD_ERR  output  1  one-cycle error pulse

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high.
- Reset values:
  - All outputs and registers 0: ALU_A, ALU_B, ALU_FUNC, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR, result register, timeout counter.
  - State = IDLE.
  - RST mid-frame, mid-wait or mid-TX aborts immediately. No byte is completed afterwards.
- States: IDLE, GET_A, GET_B, GET_FN, EXEC, WAIT_RES, TX_LO, TX_HI.
- IDLE: on RX_D_VLD:
  - byte==OP_AB -> GET_A
  - byte==OP_FN -> GET_FN
  - any other byte -> CMD_ERR=1 next cycle, stay IDLE
- GET_A / GET_B: on RX_D_VLD, load ALU_A / ALU_B, advance to GET_B / GET_FN. No timeout while waiting for bytes.
- GET_FN: on RX_D_VLD, load ALU_FUNC <= RX_P_DATA[FUNC-1:0] (upper bits ignored), -> EXEC.
- EXEC: ALU_EN=1 for exactly this one cycle, -> WAIT_RES, counter cleared.
  - ALU_EN rises in the cycle after the edge that sampled the FUNC byte.
  - ALU_A/B/FUNC are stable from that cycle until the next frame loads them.
- WAIT_RES:
  - ALU_OUT_VALID=1 -> capture ALU_OUT into result register, -> TX_LO.
  - Otherwise count each cycle. After TIMEOUT cycles without valid -> CMD_ERR pulse, -> IDLE.
  - ALU_OUT_VALID outside WAIT_RES is ignored.
- TX_LO:
  - TX_D_VLD=1, TX_P_DATA=result[DATAWIDTH-1:0].
  - Transfer occurs on an edge where TX_D_VLD=1 and TX_BUSY=0. Then -> TX_HI with TX_P_DATA=result[2*DATAWIDTH-1:DATAWIDTH], TX_D_VLD still 1.
  - While TX_BUSY=1, data and valid are held unchanged.
- TX_HI: same handshake. On transfer, TX_D_VLD=0 next cycle, -> IDLE.
  - Zero-backpressure timing: low byte transferred in the first TX cycle, high byte in the second.
- RX bytes arriving in EXEC, WAIT_RES, TX_LO or TX_HI are dropped silently; no CMD_ERR.
- OP_FN after reset uses A=B=0.
- Stored A/B persist across frames until overwritten by an OP_AB frame or RST.
- CMD_ERR is never asserted on two consecutive cycles for one event.

Test Plan:
1. Frame CC,05,03,00; ALU model returns 0x0008 with valid one cycle after ALU_EN -> ALU_A=05, ALU_B=03, ALU_FUNC=0, single ALU_EN pulse; TX bytes 08 then 00; back to IDLE.
2. CC,FF,FF,02; model returns 0xFE01 -> TX bytes 01, FE. Then DD,01 with model returning 0x0000 -> ALU_A/B stay FF, ALU_FUNC=1, TX bytes 00, 00.
3. TX_BUSY held high 10 cycles when TX_D_VLD rises -> TX_P_DATA (low byte) and TX_D_VLD stable all 10 cycles; low byte accepted on first edge with TX_BUSY=0; high byte follows.
4. Byte 55 in IDLE -> CMD_ERR one-cycle pulse, no ALU_EN, state IDLE. Then CC,01,02,00 executes normally.
5. Valid frame with model never asserting valid (TIMEOUT=16) -> CMD_ERR pulse 16 cycles after WAIT_RES entry, no TX_D_VLD, next frame accepted.
6. RST asserted after CC,07 (in GET_B), and separately in TX_HI -> all outputs 0 next cycle. Following DD,00 uses A=B=0.
